// File: rtl/dmem_timer_responder.sv
// ---------------------------------------------------------------------------
// dmem_timer_responder
//
// Memory-mapped timer that answers on the core's data-memory port next to
// DMEM.
//
// The block decodes a 16-byte register window at BASE_ADDR. Reads are
// combinational from the current flop values. Writes land on the rising
// edge and are byte-lane masked.
//
// Behind the window sits a 32-bit up-counter advanced by an 8-bit
// prescaler. The counter has a compare match that sets a pending flag.
// The interrupt line is pending AND interrupt-enable.
//
// Register map (offset = i_addr[3:2]):
//   0x0 CTRL    [0] EN, [1] AUTO, [2] IE, [15:8] PSC
//   0x4 COUNT   current count, R/W
//   0x8 COMPARE compare value, R/W
//   0xC STATUS  [0] PEND, write 1 on lane 0 to clear
//
// Ports:
//   clk         system clock, all state on rising edge
//   resetn      asynchronous active-low reset
//   i_addr      byte address from the core data port
//   i_wdata     write data
//   i_we        write strobe
//   i_sel       byte lane enables (bit n -> i_wdata[8n+7:8n])
//   o_rdata     read data, combinational from address, 0 on a miss
//   o_hit       address lies inside the register window
//   o_timer_int level interrupt, PEND & IE straight from flops
// ---------------------------------------------------------------------------
module dmem_timer_responder #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_FF00,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_we,
  input  logic [3:0]  i_sel,
  output logic [31:0] o_rdata,
  output logic        o_hit,
  output logic        o_timer_int
);

  localparam logic [1:0] OFF_CTRL    = 2'd0;
  localparam logic [1:0] OFF_COUNT   = 2'd1;
  localparam logic [1:0] OFF_COMPARE = 2'd2;
  localparam logic [1:0] OFF_STATUS  = 2'd3;

  // Architectural state
  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        ie_q, ie_d;
  logic [7:0]  psc_q, psc_d;
  logic [7:0]  pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pend_q, pend_d;

  // Decode
  logic        hit;
  logic [1:0]  reg_off;
  logic        wr_en;
  logic        tick;
  logic        match;
  logic [31:0] count_wr;
  logic [31:0] compare_wr;
  logic        unused_addr_bits;

  assign hit     = (i_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_off = i_addr[3:2];
  // A write with no lanes selected is a pure no-op, including the
  // prescaler clear that a CTRL write would otherwise cause.
  assign wr_en   = hit & i_we & (|i_sel);

  // The sub-word address bits do not take part in decode.
  assign unused_addr_bits = ^i_addr[1:0];

  // The tick and the match are both evaluated on the pre-write register
  // values. A software write in the same cycle therefore never changes
  // whether this edge counts or matches.
  assign tick  = en_q & (pc_q == psc_q);
  assign match = tick & (count_q == compare_q);

  // Byte-lane merge of the bus data over the current register contents.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign count_wr[8*gi +: 8]   = i_sel[gi] ? i_wdata[8*gi +: 8] : count_q[8*gi +: 8];
    assign compare_wr[8*gi +: 8] = i_sel[gi] ? i_wdata[8*gi +: 8] : compare_q[8*gi +: 8];
  end

  // Next-state logic
  always_comb begin
    en_d      = en_q;
    auto_d    = auto_q;
    ie_d      = ie_q;
    psc_d     = psc_q;
    pc_d      = pc_q;
    count_d   = count_q;
    compare_d = compare_q;
    pend_d    = pend_q;

    // Prescaler
    if (en_q) begin
      pc_d = tick ? 8'd0 : pc_q + 8'd1;
    end else begin
      pc_d = 8'd0;
    end

    // Counter advance
    if (tick) begin
      if (match && auto_q) begin
        count_d = 32'd0;
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    // Bus writes override the counter path.
    if (wr_en) begin
      case (reg_off)
        OFF_CTRL: begin
          pc_d = 8'd0;
          if (i_sel[0]) begin
            en_d   = i_wdata[0];
            auto_d = i_wdata[1];
            ie_d   = i_wdata[2];
          end
          if (i_sel[1]) begin
            psc_d = i_wdata[15:8];
          end
        end
        OFF_COUNT:   count_d   = count_wr;
        OFF_COMPARE: compare_d = compare_wr;
        OFF_STATUS: begin
          if (i_sel[0] && i_wdata[0]) begin
            pend_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // This is applied last, so a fresh match beats a same-cycle clear.
    if (match) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      ie_q      <= 1'b0;
      psc_q     <= 8'd0;
      pc_q      <= 8'd0;
      count_q   <= 32'd0;
      compare_q <= RESET_COMPARE;
      pend_q    <= 1'b0;
    end else begin
      en_q      <= en_d;
      auto_q    <= auto_d;
      ie_q      <= ie_d;
      psc_q     <= psc_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end

  // Read mux: current flop values, zero outside the window.
  always_comb begin
    o_rdata = 32'd0;
    if (hit) begin
      case (reg_off)
        OFF_CTRL:    o_rdata = {16'd0, psc_q, 5'd0, ie_q, auto_q, en_q};
        OFF_COUNT:   o_rdata = count_q;
        OFF_COMPARE: o_rdata = compare_q;
        OFF_STATUS:  o_rdata = {31'd0, pend_q};
        default:     o_rdata = 32'd0;
      endcase
    end
  end

  assign o_hit = hit;

  // Both operands are flops, so there is no path from the bus to the
  // interrupt. The asynchronous reset clears it at once.
  assign o_timer_int = pend_q & ie_q;

endmodule

// File: tb/tb_dmem_timer_responder.sv
module tb_dmem_timer_responder;

  localparam logic [31:0] BASE = 32'h0000_FF00;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_CNT  = BASE + 32'h4;
  localparam logic [31:0] A_CMP  = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_wdata = 32'd0;
  logic        i_we = 1'b0;
  logic [3:0]  i_sel = 4'd0;
  logic [31:0] o_rdata;
  logic        o_hit;
  logic        o_timer_int;

  dmem_timer_responder #(
    .BASE_ADDR     (BASE),
    .RESET_COMPARE (32'hFFFF_FFFF)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_we        (i_we),
    .i_sel       (i_sel),
    .o_rdata     (o_rdata),
    .o_hit       (o_hit),
    .o_timer_int (o_timer_int)
  );

  always #5 clk = ~clk;

  // Scoreboard
  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: every cycle the bus presents read data, hit and the interrupt.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.name, ".rdata"}, o_rdata, e.rdata);
      check({e.name, ".hit"}, {31'd0, o_hit}, {31'd0, e.hit});
      check({e.name, ".irq"}, {31'd0, o_timer_int}, {31'd0, e.irq});
    end
  end

  // Behavioural reference model.
  // The prescaler is modelled as "enabled cycles since the last restart".
  // A tick fires on every (PSC+1)-th such cycle.
  logic        m_en, m_auto, m_ie, m_pend;
  logic [7:0]  m_psc;
  logic [31:0] m_count, m_compare;
  int          m_phase;

  task automatic m_reset();
    m_en = 0; m_auto = 0; m_ie = 0; m_pend = 0; m_psc = 8'd0;
    m_count = 32'd0; m_compare = 32'hFFFF_FFFF; m_phase = 0;
  endtask

  function automatic logic m_hit(input logic [31:0] a);
    return a[31:4] == BASE[31:4];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_hit(a)) return 32'd0;
    case (a[3:2])
      2'd0:    return {16'd0, m_psc, 5'd0, m_ie, m_auto, m_en};
      2'd1:    return m_count;
      2'd2:    return m_compare;
      default: return {31'd0, m_pend};
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w, input logic [3:0] sel);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  task automatic m_step(input logic [31:0] a, input logic [31:0] w, input logic we, input logic [3:0] sel);
    int          p = int'(m_psc);
    logic        tick, match;
    logic [31:0] old_count = m_count;
    tick  = m_en && ((m_phase % (p + 1)) == p);
    match = tick && (m_count == m_compare);
    if (m_en) m_phase++; else m_phase = 0;
    if (tick) m_count = (match && m_auto) ? 32'd0 : m_count + 32'd1;
    if (match) m_pend = 1'b1;
    if (we && m_hit(a) && sel != 4'd0) begin
      case (a[3:2])
        2'd0: begin
          m_phase = 0;
          if (sel[0]) begin m_en = w[0]; m_auto = w[1]; m_ie = w[2]; end
          if (sel[1]) m_psc = w[15:8];
        end
        2'd1: m_count = merge(old_count, w, sel);
        2'd2: m_compare = merge(m_compare, w, sel);
        default: if (sel[0] && w[0] && !match) m_pend = 1'b0;
      endcase
    end
  endtask

  // One bus cycle: drive, predict, clock the model.
  task automatic cyc(input string name, input logic [31:0] a, input logic [31:0] w,
                     input logic we, input logic [3:0] sel);
    exp_t e;
    i_addr = a; i_wdata = w; i_we = we; i_sel = sel;
    e.name = name; e.rdata = m_read(a); e.hit = m_hit(a); e.irq = m_pend & m_ie;
    sb_q.push_back(e);
    @(posedge clk);
    m_step(a, w, we, sel);
    #1;
  endtask

  task automatic rd(input string name, input logic [31:0] a);
    cyc(name, a, 32'd0, 1'b0, 4'd0);
  endtask

  task automatic wr(input string name, input logic [31:0] a, input logic [31:0] w, input logic [3:0] sel);
    cyc(name, a, w, 1'b1, sel);
  endtask

  // Asynchronous reset in the middle of a cycle.
  // The interrupt and the registers must drop before the next clock edge.
  task automatic do_reset();
    i_we = 1'b0; i_sel = 4'd0; i_addr = A_CNT;
    #2 resetn = 1'b0;
    #1;
    check("reset.irq_async", {31'd0, o_timer_int}, 32'd0);
    check("reset.count_async", o_rdata, 32'd0);
    m_reset();
    @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    // Reset values
    rd("rst.ctrl", A_CTRL);
    rd("rst.count", A_CNT);
    rd("rst.compare", A_CMP);
    rd("rst.status", A_STAT);

    // Prescaler: PSC=2, IE=1, EN=1
    wr("psc.cmp", A_CMP, 32'd3, 4'hF);
    wr("psc.ctrl", A_CTRL, 32'h0000_0205, 4'hF);
    for (int n = 0; n < 16; n++) rd("psc.count", A_CNT);
    rd("psc.status", A_STAT);

    // Reset mid-count with PEND=1
    rd("psc.pend_before_rst", A_STAT);
    do_reset();
    rd("rst2.ctrl", A_CTRL);
    rd("rst2.count", A_CNT);
    rd("rst2.compare", A_CMP);
    rd("rst2.status", A_STAT);

    // Auto-reload: COMPARE=2, EN|AUTO|IE, PSC=0
    wr("auto.cmp", A_CMP, 32'd2, 4'hF);
    wr("auto.ctrl", A_CTRL, 32'h0000_0007, 4'hF);
    for (int n = 0; n < 8; n++) rd("auto.count", A_CNT);
    wr("auto.w1c", A_STAT, 32'd1, 4'h1);
    for (int n = 0; n < 5; n++) rd("auto.status", A_STAT);

    // Byte lanes
    do_reset();
    wr("lane.cmp0101", A_CMP, 32'hAABB_CCDD, 4'b0101);
    rd("lane.read", A_CMP);
    wr("lane.sel0", A_CMP, 32'h1234_5678, 4'b0000);
    rd("lane.unchanged", A_CMP);

    // Collisions: COUNT write in a tick cycle, then W1C in a match cycle
    wr("col.cmp", A_CMP, 32'd12, 4'hF);
    wr("col.ctrl", A_CTRL, 32'h0000_0001, 4'hF);
    wr("col.cnt100", A_CNT, 32'd100, 4'hF);
    rd("col.cnt_read", A_CNT);
    wr("col.cnt10", A_CNT, 32'd10, 4'hF);
    for (int n = 0; n < 3; n++) wr("col.w1c", A_STAT, 32'd1, 4'h1);
    rd("col.pend", A_STAT);

    // Decode: one past the window
    wr("dec.miss_wr", BASE + 32'h10, 32'h0000_0000, 4'hF);
    rd("dec.miss_rd", BASE + 32'h10);
    rd("dec.ctrl_kept", A_CTRL);

    // Wrap
    do_reset();
    wr("wrap.cnt", A_CNT, 32'hFFFF_FFFF, 4'hF);
    wr("wrap.cmp", A_CMP, 32'd5, 4'hF);
    wr("wrap.ctrl", A_CTRL, 32'h0000_0001, 4'hF);
    rd("wrap.before", A_CNT);
    rd("wrap.after", A_CNT);
    rd("wrap.status", A_STAT);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, w;
      logic [3:0]  sel;
      logic        we;
      logic [1:0]  off;
      if (n % 200 == 199) do_reset();
      off = 2'($urandom_range(0, 3));
      a   = BASE + {28'd0, off, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) a = ($urandom_range(0, 1) == 0) ? BASE + 32'h10 : $urandom;
      we  = ($urandom_range(0, 2) == 0);
      sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      w   = $urandom;
      case (off)
        2'd0: w = {16'd0, 8'($urandom_range(0, 3)), 5'd0, 3'($urandom_range(0, 7))};
        2'd1: begin w = 32'($urandom_range(0, 12)); sel = we ? 4'hF : 4'h0; end
        2'd2: w = 32'($urandom_range(0, 12));
        default: ;
      endcase
      cyc("rand", a, w, we, sel);
    end

    // Drain, with a bounded wait.
    for (int n = 0; n < 10 && sb_q.size() > 0; n++) @(posedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
